// File: rtl/bus_sram_slave_pkg.sv
// bus_sram_slave_pkg: shared types and constants for the bus SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, window geometry, beat counter width, and the
// begin-error / read-abort rules shared by the top and its bench-facing logic.
package bus_sram_slave_pkg;

  // Memory window: 4 KB of byte address space holding 1024 32-bit words.
  localparam int unsigned WINDOW_BYTES = 4096;
  localparam int unsigned WINDOW_LSB   = $clog2(WINDOW_BYTES);
  localparam int unsigned WORD_ADDR_W  = 10;

  // Beat counter holds burstSizeIn+1, i.e. 1..256.
  localparam int unsigned BEAT_CNT_W   = 9;

  // Error / abort constants.
  localparam logic [3:0] BE_FULL      = 4'hF;
  localparam logic [1:0] WORD_ALIGNED = 2'b00;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_INIT = 3'd2,
    READ      = 3'd3,
    ERROR     = 3'd4,
    END       = 3'd5
  } state_e;

  // A claimed begin is rejected when it is not word aligned, or when it asks
  // for a multi-beat burst with anything other than full-word enables.
  function automatic logic begin_is_bad(input logic [1:0] byte_off,
                                        input logic [7:0] burst,
                                        input logic [3:0] be);
    return (byte_off != WORD_ALIGNED) || ((burst != 8'd0) && (be != BE_FULL));
  endfunction

  // A read in flight is abandoned if the master ends it or signals an error.
  function automatic logic read_abort(input logic end_in, input logic err_in);
    return end_in | err_in;
  endfunction

endpackage

// File: rtl/bus_sram_slave_sram.sv
// sram1024X32Sp: 1024x32 single-port SRAM with byte-write enables.
// Latency: read data registered, valid the cycle after rd_en; writes land at the clock edge.
// Backpressure: none; rd_dat holds its value while rd_en is low.
//
// Ports: clock; rd_en/wr_en strobes (never both from the controller);
// wr_be byte lanes; addr word address; wr_dat write data; rd_dat read data.
// Contents are not reset.
module sram1024X32Sp
  import bus_sram_slave_pkg::*;
(
  input  logic                   clock,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [3:0]             wr_be,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [31:0]            wr_dat,
  output logic [31:0]            rd_dat
);

  logic [31:0] mem [0:(1<<WORD_ADDR_W)-1];
  logic [31:0] rd_dat_q, rd_dat_d;

  // Holding the last read word lets the controller stall a read beat by
  // simply not re-issuing the read.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem[addr];
    end
  end

  always_ff @(posedge clock) begin
    rd_dat_q <= rd_dat_d;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[addr][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/bus_sram_slave.sv
// bus_sram_slave: wired-OR bus responder fronting a 1024x32 SRAM window at slaveBaseAddress.
// Latency: first read word 2 cycles after the begin cycle, then one word per cycle; writes one beat per cycle.
// Backpressure: busyIn holds the current read beat; busyOut (BUS_SRAM_SLAVE_BUSY_EN only) stalls every 4th active cycle.
//
// Ports: clock, reset (synchronous, active-high); bus inputs beginTransactionIn,
// endTransactionIn, readNotWriteIn, dataValidIn, busErrorIn, busyIn,
// addressDataIn[31:0], byteEnablesIn[3:0], burstSizeIn[7:0]; bus outputs
// endTransactionOut, dataValidOut, busErrorOut, busyOut, addressDataOut[31:0],
// all zero whenever this block is not the active responder.
// Config macro: BUS_SRAM_SLAVE_BUSY_EN enables the self-generated busyOut
// counter; when undefined busyOut is tied low.
module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter logic [31:0] slaveBaseAddress = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        busErrorIn,
  input  logic        busyIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  output logic        endTransactionOut,
  output logic        dataValidOut,
  output logic        busErrorOut,
  output logic        busyOut,
  output logic [31:0] addressDataOut
);

  state_e                 state_q, state_d;
  logic [WORD_ADDR_W-1:0] word_addr_q, word_addr_d;
  logic                   rnw_q, rnw_d;
  logic [3:0]             be_q, be_d;
  logic [BEAT_CNT_W-1:0]  beats_left_q, beats_left_d;

  logic                   claim;
  logic                   busy_self;
  logic [WORD_ADDR_W-1:0] word_addr_inc;

  logic                   sram_rd_en;
  logic                   sram_wr_en;
  logic [WORD_ADDR_W-1:0] sram_addr;
  logic [31:0]            sram_rd_dat;

  logic                   resp_end;
  logic                   resp_vld;
  logic                   resp_err;
  logic [31:0]            resp_dat;

  assign claim = beginTransactionIn &&
                 (addressDataIn[31:WINDOW_LSB] == slaveBaseAddress[31:WINDOW_LSB]);

  // Natural 10-bit overflow gives the 1023 -> 0 wrap.
  assign word_addr_inc = word_addr_q + WORD_ADDR_W'(1);

`ifdef BUS_SRAM_SLAVE_BUSY_EN
  logic [1:0] busy_cnt_q, busy_cnt_d;
  logic       busy_active;

  assign busy_active = (state_q == WRITE) || (state_q == READ);

  always_comb begin
    busy_cnt_d = 2'd0;
    if (busy_active) begin
      busy_cnt_d = busy_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt_q <= 2'd0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Gated by state so the count left over on exit never leaks onto the bus.
  assign busy_self = busy_active && (busy_cnt_q == 2'd3);
`else
  assign busy_self = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    word_addr_d  = word_addr_q;
    rnw_d        = rnw_q;
    be_d         = be_q;
    beats_left_d = beats_left_q;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_addr    = word_addr_q;
    resp_end     = 1'b0;
    resp_vld     = 1'b0;
    resp_err     = 1'b0;
    resp_dat     = '0;

    unique case (state_q)
      IDLE: begin
        if (claim) begin
          word_addr_d  = addressDataIn[WINDOW_LSB-1:2];
          rnw_d        = readNotWriteIn;
          be_d         = byteEnablesIn;
          beats_left_d = BEAT_CNT_W'(burstSizeIn) + BEAT_CNT_W'(1);
          if (begin_is_bad(addressDataIn[1:0], burstSizeIn, byteEnablesIn)) begin
            state_d = ERROR;
          end else if (readNotWriteIn) begin
            state_d = READ_INIT;
          end else begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        // Once the beat count is spent, further data beats are dropped.
        if (dataValidIn && !busy_self && !rnw_q && (beats_left_q != '0)) begin
          sram_wr_en   = 1'b1;
          word_addr_d  = word_addr_inc;
          beats_left_d = beats_left_q - BEAT_CNT_W'(1);
        end
        if (endTransactionIn) begin
          state_d = IDLE;
        end
      end

      READ_INIT: begin
        // Prime the SRAM so the first word is on its output in READ.
        sram_rd_en = 1'b1;
        state_d    = read_abort(endTransactionIn, busErrorIn) ? IDLE : READ;
      end

      READ: begin
        if (!busy_self) begin
          resp_vld = 1'b1;
          resp_dat = sram_rd_dat;
        end
        if (read_abort(endTransactionIn, busErrorIn)) begin
          state_d = IDLE;
        end else if (!busy_self && !busyIn && rnw_q) begin
          if (beats_left_q == BEAT_CNT_W'(1)) begin
            resp_end     = 1'b1;
            beats_left_d = '0;
            state_d      = IDLE;
          end else begin
            // Fetch the next word now so it is presented next cycle; while
            // stalled no read is issued and the SRAM output holds.
            word_addr_d  = word_addr_inc;
            beats_left_d = beats_left_q - BEAT_CNT_W'(1);
            sram_addr    = word_addr_inc;
            sram_rd_en   = 1'b1;
          end
        end
      end

      ERROR: begin
        resp_err = 1'b1;
        state_d  = END;
      end

      END: begin
        resp_end = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      word_addr_q  <= '0;
      rnw_q        <= 1'b0;
      be_q         <= 4'h0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      rnw_q        <= rnw_d;
      be_q         <= be_d;
      beats_left_q <= beats_left_d;
    end
  end

  sram1024X32Sp u_sram (
    .clock  (clock),
    .rd_en  (sram_rd_en),
    .wr_en  (sram_wr_en),
    .wr_be  (be_q),
    .addr   (sram_addr),
    .wr_dat (addressDataIn),
    .rd_dat (sram_rd_dat)
  );

  assign endTransactionOut = resp_end;
  assign dataValidOut      = resp_vld;
  assign busErrorOut       = resp_err;
  assign busyOut           = busy_self;
  assign addressDataOut    = resp_dat;

endmodule
